// File: rtl/ud_sweep_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
package ud_sweep_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_NSW_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/ud_step_counter.sv
// WIDTH-bit up/down counter datapath; load has priority over count enable.
module ud_step_counter
  import ud_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = d;
    end else if (en) begin
      cnt_d = dir ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/ud_sweep_ctrl.sv
// Triangular lo..hi..lo sweep sequencer driving ud_step_counter, with
// start/stop handshake, finite or continuous sweep count, done/err pulses.
module ud_sweep_ctrl
  import ud_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned NSW_W = DEFAULT_NSW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [NSW_W-1:0] sweeps,
  output logic [WIDTH-1:0] q,
  output logic             up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NSW_W-1:0] sweep_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [NSW_W-1:0] sweeps_q, sweeps_d;
  logic [NSW_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic             up_q, up_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_en_c;
  logic             cnt_dir_c;
  logic             cnt_load_c;
  logic [WIDTH-1:0] cnt_d_c;
  logic [WIDTH-1:0] cnt_q;
  logic [NSW_W-1:0] sweep_inc_c;

  assign sweep_inc_c = sweep_cnt_q + NSW_W'(1);

  ud_step_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en_c),
    .dir (cnt_dir_c),
    .load(cnt_load_c),
    .d   (cnt_d_c),
    .q   (cnt_q)
  );

  // Next-state, counter control and pulse generation; stop outranks bound hits.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    up_d        = up_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_en_c    = 1'b0;
    cnt_dir_c   = 1'b1;
    cnt_load_c  = 1'b0;
    cnt_d_c     = lo;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo < hi) begin
            lo_d        = lo;
            hi_d        = hi;
            sweeps_d    = sweeps;
            sweep_cnt_d = '0;
            up_d        = 1'b1;
            cnt_load_c  = 1'b1;
            state_d     = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (stop) begin
          up_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == hi_q) begin
          cnt_en_c  = 1'b1;
          cnt_dir_c = 1'b0;
          up_d      = 1'b0;
          state_d   = ST_DOWN;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      ST_DOWN: begin
        if (stop) begin
          up_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != lo_q) begin
          cnt_en_c  = 1'b1;
          cnt_dir_c = 1'b0;
        end else begin
          sweep_cnt_d = sweep_inc_c;
          up_d        = 1'b1;
          if ((sweeps_q != '0) && (sweep_inc_c == sweeps_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_en_c = 1'b1;
            state_d  = ST_UP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      up_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      up_q        <= up_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign q         = cnt_q;
  assign up        = up_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// Directed bench for ud_sweep_ctrl: one task per scenario, inline checks.
module tb_ud_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] sweeps;
  logic [3:0] q;
  logic       up;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_cnt;

  int errors;
  int checks;

  ud_sweep_ctrl #(.WIDTH(4), .NSW_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo(lo), .hi(hi), .sweeps(sweeps),
    .q(q), .up(up), .busy(busy), .done(done), .err(err),
    .sweep_cnt(sweep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (q !== 4'd0)        begin errors++; $display("FAIL reset_q got %0d exp 0", q); end
    checks++; if (up !== 1'b1)       begin errors++; $display("FAIL reset_up got %0b exp 1", up); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    checks++; if (sweep_cnt !== 4'd0) begin errors++; $display("FAIL reset_sweep_cnt got %0d exp 0", sweep_cnt); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_sweep();
    logic [3:0] exp_q  [7];
    logic       exp_up [7];
    exp_q  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    exp_up = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lo = 4'd2; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
      checks++; if (q !== exp_q[i])   begin errors++; $display("FAIL single_q cyc%0d got %0d exp %0d", i + 1, q, exp_q[i]); end
      checks++; if (up !== exp_up[i]) begin errors++; $display("FAIL single_up cyc%0d got %0b exp %0b", i + 1, up, exp_up[i]); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_busy cyc%0d got busy=%0b done=%0b exp 1/0", i + 1, busy, done); end
    end
    step();
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL single_done got %0b exp 1", done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_idle_busy got %0b exp 0", busy); end
    checks++; if (sweep_cnt !== 4'd1) begin errors++; $display("FAIL single_sweep_cnt got %0d exp 1", sweep_cnt); end
    checks++; if (q !== 4'd2 || up !== 1'b1) begin errors++; $display("FAIL single_hold got q=%0d up=%0b exp 2/1", q, up); end
    step();
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL single_done_pulse got %0b exp 0", done); end
  endtask

  task automatic test_full_range();
    int n;
    int peaks;
    lo = 4'd0; hi = 4'd15; sweeps = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    peaks = 0;
    while (done !== 1'b1 && n < 200) begin
      if (q == 4'd15 && up == 1'b1) peaks++;
      step();
      n++;
    end
    checks++; if (n !== 92)           begin errors++; $display("FAIL full_latency got %0d exp 92", n); end
    checks++; if (q !== 4'd0)         begin errors++; $display("FAIL full_q_end got %0d exp 0", q); end
    checks++; if (sweep_cnt !== 4'd3) begin errors++; $display("FAIL full_sweep_cnt got %0d exp 3", sweep_cnt); end
    checks++; if (peaks !== 3)        begin errors++; $display("FAIL full_peaks got %0d exp 3", peaks); end
    step();
  endtask

  task automatic test_reject();
    logic [3:0] los [2];
    logic [3:0] his [2];
    los = '{4'd7, 4'd9};
    his = '{4'd7, 4'd3};
    for (int k = 0; k < 2; k++) begin
      lo = los[k]; hi = his[k]; sweeps = 4'd1; start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (err !== 1'b1)  begin errors++; $display("FAIL reject%0d_err got %0b exp 1", k, err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reject%0d_busy got %0b exp 0", k, busy); end
      checks++; if (q !== 4'd0)    begin errors++; $display("FAIL reject%0d_q got %0d exp 0", k, q); end
      step();
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reject%0d_pulse got err=%0b busy=%0b exp 0/0", k, err, busy); end
    end
  endtask

  task automatic test_continuous_stop();
    int n;
    lo = 4'd1; hi = 4'd4; sweeps = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) step();
    checks++; if (q !== 4'd2 || up !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cont_wrap got q=%0d up=%0b busy=%0b exp 2/1/1", q, up, busy); end
    checks++; if (sweep_cnt !== 4'd1 || done !== 1'b0) begin errors++; $display("FAIL cont_count got cnt=%0d done=%0b exp 1/0", sweep_cnt, done); end
    for (int c = 9; c <= 11; c++) step();
    checks++; if (q !== 4'd3 || up !== 1'b0) begin errors++; $display("FAIL cont_pre_stop got q=%0d up=%0b exp 3/0", q, up); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || q !== 4'd3) begin errors++; $display("FAIL stop_state got busy=%0b q=%0d exp 0/3", busy, q); end
    checks++; if (up !== 1'b1 || done !== 1'b0 || sweep_cnt !== 4'd1) begin errors++; $display("FAIL stop_outs got up=%0b done=%0b cnt=%0d exp 1/0/1", up, done, sweep_cnt); end
    stop = 1'b1;
    step();
    step();
    stop = 1'b0;
    checks++; if (q !== 4'd3 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_idle got q=%0d busy=%0b done=%0b exp 3/0/0", q, busy, done); end
    lo = 4'd6; hi = 4'd9; sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (q !== 4'd6 || sweep_cnt !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart got q=%0d cnt=%0d busy=%0b exp 6/0/1", q, sweep_cnt, busy); end
    n = 1;
    while (done !== 1'b1 && n < 50) begin step(); n++; end
    checks++; if (n !== 8) begin errors++; $display("FAIL restart_done got %0d exp 8", n); end
    step();
  endtask

  task automatic test_back_to_back();
    lo = 4'd3; hi = 4'd6; sweeps = 4'd2; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b1 || q !== 4'd3) begin errors++; $display("FAIL startstop got busy=%0b q=%0d exp 1/3", busy, q); end
    step(); step(); step();
    checks++; if (q !== 4'd6 || up !== 1'b1) begin errors++; $display("FAIL b2b_peak got q=%0d up=%0b exp 6/1", q, up); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || q !== 4'd6 || up !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stop_at_hi got busy=%0b q=%0d up=%0b done=%0b exp 0/6/1/0", busy, q, up, done); end
  endtask

  task automatic test_ignored_start();
    logic [3:0] exp_q [7];
    exp_q = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd7, 4'd6, 4'd5};
    lo = 4'd5; hi = 4'd8; sweeps = 4'd1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = (i == 1);
      if (i == 1) begin lo = 4'd0; hi = 4'd2; sweeps = 4'd0; end
      checks++; if (q !== exp_q[i] || err !== 1'b0) begin errors++; $display("FAIL busy_start cyc%0d got q=%0d err=%0b exp %0d/0", i + 1, q, err, exp_q[i]); end
    end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b1 || q !== 4'd5 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_done got done=%0b q=%0d busy=%0b exp 1/5/0", done, q, busy); end
    step();
  endtask

  task automatic test_reset_mid();
    lo = 4'd2; hi = 4'd5; sweeps = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (q !== 4'd0 || up !== 1'b1) begin errors++; $display("FAIL rst_mid got q=%0d up=%0b exp 0/1", q, up); end
    checks++; if (busy !== 1'b0 || sweep_cnt !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl got busy=%0b cnt=%0d done=%0b exp 0/0/0", busy, sweep_cnt, done); end
    step();
    checks++; if (done !== 1'b0 || q !== 4'd0) begin errors++; $display("FAIL rst_hold got done=%0b q=%0d exp 0/0", done, q); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || q !== 4'd0) begin errors++; $display("FAIL rst_release got busy=%0b q=%0d exp 0/0", busy, q); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    lo = '0; hi = '0; sweeps = '0;
    test_reset();
    test_single_sweep();
    test_full_range();
    test_reject();
    test_continuous_stop();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
